// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults and width helpers for the FIR MAC accumulator
package fir_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int LENGTH_DEF = 64;
    localparam int CNT_W = 8;
    function automatic int acc_width(input int w);
        return 2 * w + 6;
    endfunction
endpackage

// File: rtl/sreg_ld.sv
// sreg_ld: register with async active-low reset, synchronous clear and load
module sreg_ld #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // clear wins over load; otherwise hold
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else if (clr) q <= '0;
        else if (ld) q <= d;
endmodule

// File: rtl/fir_mac_accumulator.sv
// fir_mac_accumulator: product register, wrapping accumulator and tap counter
module fir_mac_accumulator
    import fir_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LENGTH = LENGTH_DEF,
    localparam int ACC_W = acc_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prod_ld,
    input  logic [2*WIDTH-1:0] prod_in,
    input  logic               acc_clr,
    input  logic               acc_ld,
    input  logic               cnt_clr,
    input  logic               cnt_en,
    output logic [CNT_W-1:0]   count,
    output logic               cnt_last,
    output logic [ACC_W-1:0]   acc_out,
    output logic [ACC_W-1:0]   fir_out
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);
    logic [ACC_W-1:0] prod_ext, prod_q, sum;
    assign prod_ext = {{(ACC_W-2*WIDTH){prod_in[2*WIDTH-1]}}, prod_in};
    assign sum = acc_out + prod_q;
    assign fir_out = {acc_out[ACC_W-1], acc_out[ACC_W-1:1]};
    assign cnt_last = count == LAST;
    sreg_ld #(.W(ACC_W)) u_prod (
        .clk(clk), .rst(rst), .clr(1'b0), .ld(prod_ld), .d(prod_ext), .q(prod_q)
    );
    sreg_ld #(.W(ACC_W)) u_acc (
        .clk(clk), .rst(rst), .clr(acc_clr), .ld(acc_ld), .d(sum), .q(acc_out)
    );
    // tap counter: clear beats enable, wraps after the last tap
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (cnt_clr) count <= '0;
        else if (cnt_en) count <= cnt_last ? '0 : count + 1'b1;
endmodule

// File: tb/tb_fir_mac_accumulator.sv
// tb_fir_mac_accumulator: directed checks of the FIR MAC accumulator
module tb_fir_mac_accumulator;
    logic clk = 0, rst = 0;
    logic prod_ld = 0, acc_clr = 0, acc_ld = 0, cnt_clr = 0, cnt_en = 0;
    logic [31:0] prod_in = 0;
    logic [7:0] count;
    logic cnt_last;
    logic signed [37:0] acc_out, fir_out;
    int checks = 0, failures = 0;
    longint big;

    fir_mac_accumulator dut (
        .clk(clk), .rst(rst), .prod_ld(prod_ld), .prod_in(prod_in),
        .acc_clr(acc_clr), .acc_ld(acc_ld), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .count(count), .cnt_last(cnt_last), .acc_out(acc_out), .fir_out(fir_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prod(input logic [31:0] v);
        prod_in = v; prod_ld = 1; step(); prod_ld = 0;
    endtask

    task automatic accum(input int n);
        acc_ld = 1;
        repeat (n) step();
        acc_ld = 0;
    endtask

    initial begin
        prod_ld = 1; acc_clr = 1; acc_ld = 1; cnt_clr = 1; cnt_en = 1; prod_in = 5;
        #2;
        repeat (3) begin
            step();
            check("rst_count", count, 0);
            check("rst_acc", acc_out, 0);
            check("rst_fir", fir_out, 0);
            check("rst_last", cnt_last, 0);
        end
        prod_ld = 0; acc_clr = 0; acc_ld = 0; cnt_clr = 0; cnt_en = 0;
        rst = 1;
        load_prod(3);
        accum(4);
        check("acc_12", acc_out, 12);
        check("fir_6", fir_out, 6);
        load_prod(-20);
        accum(1);
        check("acc_m8", acc_out, -8);
        check("fir_m4", fir_out, -4);
        load_prod(7);
        accum(1);
        check("acc_m1", acc_out, -1);
        check("fir_m1", fir_out, -1);
        load_prod(-2);
        accum(1);
        check("acc_m3", acc_out, -3);
        check("fir_m2", fir_out, -2);
        acc_clr = 1; acc_ld = 1; step(); acc_clr = 0; acc_ld = 0;
        check("acc_clr_prio", acc_out, 0);
        prod_in = 100; prod_ld = 1; acc_ld = 1; step(); prod_ld = 0;
        check("same_cycle_old_prod", acc_out, -2);
        step(); acc_ld = 0;
        check("new_prod_added", acc_out, 98);
        cnt_en = 1; repeat (10) step(); cnt_en = 0;
        check("count_10", count, 10);
        cnt_clr = 1; cnt_en = 1; step(); cnt_clr = 0; cnt_en = 0;
        check("cnt_clr_prio", count, 0);
        cnt_en = 1;
        for (int i = 0; i < 64; i++) begin
            check("wrap_count", count, i);
            check("wrap_last", cnt_last, i == 63);
            step();
        end
        cnt_en = 0;
        check("wrap_zero", count, 0);
        check("wrap_last_off", cnt_last, 0);
        acc_clr = 1; step(); acc_clr = 0;
        load_prod(32'h7FFF_FFFF);
        accum(64);
        load_prod(63);
        accum(1);
        big = (longint'(1) <<< 37) - 1;
        check("acc_max", acc_out, big);
        load_prod(1);
        accum(1);
        check("acc_ovf_wrap", acc_out, -(longint'(1) <<< 37));
        check("fir_ovf_wrap", fir_out, -(longint'(1) <<< 36));
        acc_clr = 1; cnt_clr = 1; step(); acc_clr = 0; cnt_clr = 0;
        cnt_en = 1; repeat (17) step(); cnt_en = 0;
        load_prod(500);
        accum(1);
        check("pre_rst_count", count, 17);
        check("pre_rst_acc", acc_out, 500);
        #2 rst = 0;
        #1;
        check("async_count", count, 0);
        check("async_acc", acc_out, 0);
        check("async_fir", fir_out, 0);
        step();
        rst = 1;
        acc_ld = 1; step(); acc_ld = 0;
        check("post_rst_acc", acc_out, 0);
        check("post_rst_count", count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
